// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe
// Hazard and forwarding controller for a five-stage MIPS pipeline, placed
// beside the main decoder in ID. It produces EX operand forwarding selects,
// multi-cycle load-use stalls (LOAD_LAT bubbles), a global freeze while data
// memory is busy, and IF/ID flushes on taken branches and jumps. Two
// saturating counters record stall cycles and flush cycles.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   id_rs/id_rt, id_uses_*      sources of the ID instruction, and whether read
//   ex_rs/ex_rt/ex_rd           ID/EX sources and destination
//   ex_mem_read                 ID/EX holds a load
//   mem_rd/mem_reg_write        EX/MEM destination and write enable
//   wb_rd/wb_reg_write          MEM/WB destination and write enable
//   branch_taken, jump          ID-stage redirect request
//   dmem_req, dmem_ready        data-memory access handshake in MEM
//   pc_write, ifid_write        PC and IF/ID enables
//   idex_bubble                 load a NOP into ID/EX
//   pipe_freeze                 hold ID/EX, EX/MEM and MEM/WB
//   ifid_flush                  zero IF/ID
//   fwd_a, fwd_b                00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_cnt, flush_cnt        saturating performance counters
module hazard_ctrl_pipe #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              pipe_freeze,
    output logic              ifid_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN,
        LU_STALL,
        MEM_WAIT
    } state_t;

    // Bubbles still owed after the detect cycle; at most LOAD_LAT-1 = 2.
    localparam logic [1:0]       LAT_M1  = 2'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state, state_nx;
    state_t     ret_state, ret_state_nx;
    state_t     eff_state;
    logic [1:0] lu_left, lu_left_nx;
    logic       mem_wait;
    logic       load_use;

    // EX/MEM result takes precedence over the older MEM/WB result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        if (m_we && m_rd != '0 && m_rd == src)      return 2'b10;
        else if (w_we && w_rd != '0 && w_rd == src) return 2'b01;
        else                                        return 2'b00;
    endfunction

    always_comb begin
        mem_wait = dmem_req && !dmem_ready;
        load_use = ex_mem_read && (ex_rd != '0) &&
                   ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        // The ready cycle of a memory wait already behaves as the state that
        // was interrupted, so a wait of N not-ready cycles costs exactly N.
        eff_state = (state == MEM_WAIT) ? ret_state : state;
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no
        // path through the branches below can leave one unassigned (no latch).
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        pipe_freeze  = 1'b0;
        ifid_flush   = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        state_nx     = state;
        ret_state_nx = ret_state;
        lu_left_nx   = lu_left;

        if (!rst) begin
            fwd_a = fwd_sel(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
            fwd_b = fwd_sel(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

            if (mem_wait) begin
                // Freeze wins over everything; lu_left simply holds.
                pipe_freeze  = 1'b1;
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                state_nx     = MEM_WAIT;
                ret_state_nx = eff_state;
            end else begin
                case (eff_state)
                    LU_STALL: begin
                        idex_bubble = 1'b1;
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        if (lu_left <= 2'd1) begin
                            state_nx   = RUN;
                            lu_left_nx = 2'd0;
                        end else begin
                            state_nx   = LU_STALL;
                            lu_left_nx = lu_left - 2'd1;
                        end
                    end
                    default: begin
                        state_nx = RUN;
                        if (load_use) begin
                            idex_bubble = 1'b1;
                            pc_write    = 1'b0;
                            ifid_write  = 1'b0;
                            if (LOAD_LAT > 1) begin
                                state_nx   = LU_STALL;
                                lu_left_nx = LAT_M1;
                            end
                        end else if (branch_taken || jump) begin
                            // Redirects seen during a stall are dropped; ID
                            // presents them again once the stall clears.
                            ifid_flush = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            lu_left   <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            ret_state <= ret_state_nx;
            lu_left   <= lu_left_nx;
            if (!pc_write && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe
// Drives two controllers from the same inputs: one with LOAD_LAT=1 and 16-bit
// counters, one with LOAD_LAT=3 and 3-bit counters. A vector table covers the
// combinational rules, hand sequences cover the multi-cycle cases, and random
// stimulus is compared every cycle against a bubble-debt model.
module tb_hazard_ctrl_pipe;

    typedef struct {
        logic [4:0] id_rs, id_rt;
        logic       id_uses_rs, id_uses_rt;
        logic [4:0] ex_rs, ex_rt, ex_rd;
        logic       ex_mem_read;
        logic [4:0] mem_rd;
        logic       mem_reg_write;
        logic [4:0] wb_rd;
        logic       wb_reg_write;
        logic       branch_taken, jump, dmem_req, dmem_ready;
    } in_t;

    typedef struct {
        logic       pc, ifw, bub, frz, fl;
        logic [1:0] fa, fb;
    } out_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [1:0] fa, fb;
        logic       pc, bub, fl, frz;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    logic       d1_pc, d1_ifw, d1_bub, d1_frz, d1_fl;
    logic [1:0] d1_fa, d1_fb;
    logic [15:0] d1_sc, d1_fc;
    logic       d3_pc, d3_ifw, d3_bub, d3_frz, d3_fl;
    logic [1:0] d3_fa, d3_fb;
    logic [2:0] d3_sc, d3_fc;

    hazard_ctrl_pipe #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst),
        .id_rs(cur.id_rs), .id_rt(cur.id_rt),
        .id_uses_rs(cur.id_uses_rs), .id_uses_rt(cur.id_uses_rt),
        .ex_rs(cur.ex_rs), .ex_rt(cur.ex_rt), .ex_rd(cur.ex_rd),
        .ex_mem_read(cur.ex_mem_read),
        .mem_rd(cur.mem_rd), .mem_reg_write(cur.mem_reg_write),
        .wb_rd(cur.wb_rd), .wb_reg_write(cur.wb_reg_write),
        .branch_taken(cur.branch_taken), .jump(cur.jump),
        .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .pc_write(d1_pc), .ifid_write(d1_ifw), .idex_bubble(d1_bub),
        .pipe_freeze(d1_frz), .ifid_flush(d1_fl),
        .fwd_a(d1_fa), .fwd_b(d1_fb),
        .stall_cnt(d1_sc), .flush_cnt(d1_fc)
    );

    hazard_ctrl_pipe #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(3)) u_d3 (
        .clk(clk), .rst(rst),
        .id_rs(cur.id_rs), .id_rt(cur.id_rt),
        .id_uses_rs(cur.id_uses_rs), .id_uses_rt(cur.id_uses_rt),
        .ex_rs(cur.ex_rs), .ex_rt(cur.ex_rt), .ex_rd(cur.ex_rd),
        .ex_mem_read(cur.ex_mem_read),
        .mem_rd(cur.mem_rd), .mem_reg_write(cur.mem_reg_write),
        .wb_rd(cur.wb_rd), .wb_reg_write(cur.wb_reg_write),
        .branch_taken(cur.branch_taken), .jump(cur.jump),
        .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .pc_write(d3_pc), .ifid_write(d3_ifw), .idex_bubble(d3_bub),
        .pipe_freeze(d3_frz), .ifid_flush(d3_fl),
        .fwd_a(d3_fa), .fwd_b(d3_fb),
        .stall_cnt(d3_sc), .flush_cnt(d3_fc)
    );

    // Reference model: each load-use detect creates a debt of LOAD_LAT bubble
    // cycles, paid one per unfrozen cycle. Counters are plain saturating ints.
    int lat[2]  = '{1, 3};
    int cmax[2] = '{65535, 7};
    int owed[2] = '{0, 0};
    int sc[2]   = '{0, 0};
    int fc[2]   = '{0, 0};

    function automatic in_t idle();
        in_t i;
        i.id_rs = 0; i.id_rt = 0; i.id_uses_rs = 0; i.id_uses_rt = 0;
        i.ex_rs = 0; i.ex_rt = 0; i.ex_rd = 0; i.ex_mem_read = 0;
        i.mem_rd = 0; i.mem_reg_write = 0; i.wb_rd = 0; i.wb_reg_write = 0;
        i.branch_taken = 0; i.jump = 0; i.dmem_req = 0; i.dmem_ready = 0;
        return i;
    endfunction

    function automatic in_t fw(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] mrd, input logic mw,
                               input logic [4:0] wrd, input logic ww);
        in_t i = idle();
        i.ex_rs = rs; i.ex_rt = rt; i.mem_rd = mrd; i.mem_reg_write = mw;
        i.wb_rd = wrd; i.wb_reg_write = ww;
        return i;
    endfunction

    function automatic in_t lu(input logic [4:0] irs, input logic [4:0] irt,
                               input logic urs, input logic urt,
                               input logic [4:0] erd, input logic mr,
                               input logic j, input logic dreq, input logic drdy);
        in_t i = idle();
        i.id_rs = irs; i.id_rt = irt; i.id_uses_rs = urs; i.id_uses_rt = urt;
        i.ex_rd = erd; i.ex_mem_read = mr; i.jump = j;
        i.dmem_req = dreq; i.dmem_ready = drdy;
        return i;
    endfunction

    function automatic vec_t mkv(input string n, input in_t i,
                                 input logic [1:0] fa, input logic [1:0] fb,
                                 input logic pc, input logic bub,
                                 input logic fl, input logic frz);
        vec_t v;
        v.name = n; v.in = i; v.fa = fa; v.fb = fb;
        v.pc = pc; v.bub = bub; v.fl = fl; v.frz = frz;
        return v;
    endfunction

    function automatic logic [1:0] ref_fwd(input in_t i, input logic [4:0] src);
        if (i.mem_reg_write && i.mem_rd != 0 && i.mem_rd == src) return 2'b10;
        if (i.wb_reg_write && i.wb_rd != 0 && i.wb_rd == src)    return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_lu(input in_t i);
        return i.ex_mem_read && i.ex_rd != 0 &&
               ((i.id_uses_rs && i.id_rs == i.ex_rd) || (i.id_uses_rt && i.id_rt == i.ex_rd));
    endfunction

    function automatic out_t model_out(input in_t i, input logic r, input int ow);
        out_t o;
        o.pc = 1; o.ifw = 1; o.bub = 0; o.frz = 0; o.fl = 0; o.fa = 0; o.fb = 0;
        if (r) return o;
        o.fa = ref_fwd(i, i.ex_rs);
        o.fb = ref_fwd(i, i.ex_rt);
        if (i.dmem_req && !i.dmem_ready) begin
            o.frz = 1; o.pc = 0; o.ifw = 0;
        end else if (ow > 0 || ref_lu(i)) begin
            o.bub = 1; o.pc = 0; o.ifw = 0;
        end else if (i.branch_taken || i.jump) begin
            o.fl = 1;
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic out_t actual(input int k);
        out_t o;
        if (k == 0) begin
            o.pc = d1_pc; o.ifw = d1_ifw; o.bub = d1_bub; o.frz = d1_frz;
            o.fl = d1_fl; o.fa = d1_fa; o.fb = d1_fb;
        end else begin
            o.pc = d3_pc; o.ifw = d3_ifw; o.bub = d3_bub; o.frz = d3_frz;
            o.fl = d3_fl; o.fa = d3_fa; o.fb = d3_fb;
        end
        return o;
    endfunction

    // Inputs are already in cur/rst; sample at the falling edge and compare
    // both instances against the model.
    task automatic begin_cycle();
        out_t e, a;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = model_out(cur, rst, owed[k]);
            a = actual(k);
            check($sformatf("model lat%0d pc_write", lat[k]), 32'(a.pc), 32'(e.pc));
            check($sformatf("model lat%0d ifid_write", lat[k]), 32'(a.ifw), 32'(e.ifw));
            check($sformatf("model lat%0d idex_bubble", lat[k]), 32'(a.bub), 32'(e.bub));
            check($sformatf("model lat%0d pipe_freeze", lat[k]), 32'(a.frz), 32'(e.frz));
            check($sformatf("model lat%0d ifid_flush", lat[k]), 32'(a.fl), 32'(e.fl));
            check($sformatf("model lat%0d fwd_a", lat[k]), 32'(a.fa), 32'(e.fa));
            check($sformatf("model lat%0d fwd_b", lat[k]), 32'(a.fb), 32'(e.fb));
        end
        check("model lat1 stall_cnt", 32'(d1_sc), sc[0]);
        check("model lat1 flush_cnt", 32'(d1_fc), fc[0]);
        check("model lat3 stall_cnt", 32'(d3_sc), sc[1]);
        check("model lat3 flush_cnt", 32'(d3_fc), fc[1]);
    endtask

    task automatic end_cycle();
        out_t e;
        for (int k = 0; k < 2; k++) begin
            e = model_out(cur, rst, owed[k]);
            if (rst) begin
                owed[k] = 0; sc[k] = 0; fc[k] = 0;
            end else begin
                if (!e.frz) begin
                    if (owed[k] > 0)       owed[k]--;
                    else if (ref_lu(cur))  owed[k] = lat[k] - 1;
                end
                if (!e.pc && sc[k] < cmax[k]) sc[k]++;
                if (e.fl && fc[k] < cmax[k])  fc[k]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cur = idle();
        begin_cycle();
        end_cycle();
        rst = 1'b0;
    endtask

    vec_t vecs[14];
    in_t  lu_hit;

    initial begin
        cur = idle();
        @(posedge clk);
        #1;

        vecs[0]  = mkv("fwd_mem_wins",  fw(3, 0, 3, 1, 3, 1), 2'b10, 2'b00, 1, 0, 0, 0);
        vecs[1]  = mkv("fwd_wb",        fw(3, 0, 3, 0, 3, 1), 2'b01, 2'b00, 1, 0, 0, 0);
        vecs[2]  = mkv("fwd_r0",        fw(0, 0, 0, 0, 0, 1), 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[3]  = mkv("fwd_b_mem",     fw(0, 7, 7, 1, 2, 1), 2'b00, 2'b10, 1, 0, 0, 0);
        vecs[4]  = mkv("fwd_both_wb",   fw(9, 9, 4, 1, 9, 1), 2'b01, 2'b01, 1, 0, 0, 0);
        vecs[5]  = mkv("lu_rs",         lu(5, 0, 1, 0, 5, 1, 0, 0, 0), 2'b00, 2'b00, 0, 1, 0, 0);
        vecs[6]  = mkv("lu_rs_unused",  lu(5, 0, 0, 0, 5, 1, 0, 0, 0), 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[7]  = mkv("lu_rt",         lu(0, 5, 0, 1, 5, 1, 0, 0, 0), 2'b00, 2'b00, 0, 1, 0, 0);
        vecs[8]  = mkv("lu_r0",         lu(0, 0, 1, 1, 0, 1, 0, 0, 0), 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[9]  = mkv("jump",          lu(0, 0, 0, 0, 0, 0, 1, 0, 0), 2'b00, 2'b00, 1, 0, 1, 0);
        vecs[10] = mkv("jump_with_lu",  lu(5, 0, 1, 0, 5, 1, 1, 0, 0), 2'b00, 2'b00, 0, 1, 0, 0);
        vecs[11] = mkv("memwait_wins",  lu(5, 0, 1, 0, 5, 1, 1, 1, 0), 2'b00, 2'b00, 0, 0, 0, 1);
        vecs[12] = mkv("mem_ready",     lu(0, 0, 0, 0, 0, 0, 0, 1, 1), 2'b00, 2'b00, 1, 0, 0, 0);
        vecs[13] = mkv("branch",        idle(), 2'b00, 2'b00, 1, 0, 1, 0);
        vecs[13].in.branch_taken = 1'b1;

        for (int v = 0; v < 14; v++) begin
            do_reset();
            cur = vecs[v].in;
            begin_cycle();
            check({vecs[v].name, " fwd_a"},       32'(d1_fa),  32'(vecs[v].fa));
            check({vecs[v].name, " fwd_b"},       32'(d1_fb),  32'(vecs[v].fb));
            check({vecs[v].name, " pc_write"},    32'(d1_pc),  32'(vecs[v].pc));
            check({vecs[v].name, " idex_bubble"}, 32'(d1_bub), 32'(vecs[v].bub));
            check({vecs[v].name, " ifid_flush"},  32'(d1_fl),  32'(vecs[v].fl));
            check({vecs[v].name, " pipe_freeze"}, 32'(d3_frz), 32'(vecs[v].frz));
            end_cycle();
        end

        lu_hit = lu(5, 0, 1, 0, 5, 1, 0, 0, 0);

        // LOAD_LAT=1: one bubble, stall_cnt 0 -> 1.
        do_reset();
        cur = lu_hit;
        begin_cycle();
        check("lat1 bubble", 32'(d1_bub), 1);
        check("lat1 stall_cnt before", 32'(d1_sc), 0);
        end_cycle();
        cur = idle();
        begin_cycle();
        check("lat1 released", 32'(d1_pc), 1);
        check("lat1 stall_cnt after", 32'(d1_sc), 1);
        end_cycle();

        // LOAD_LAT=3: three consecutive bubbles from one detect.
        do_reset();
        cur = lu_hit;
        for (int k = 0; k < 3; k++) begin
            begin_cycle();
            check($sformatf("lat3 bubble %0d", k), 32'(d3_bub), 1);
            check($sformatf("lat3 pc_write %0d", k), 32'(d3_pc), 0);
            end_cycle();
            cur = idle();
        end
        begin_cycle();
        check("lat3 released", 32'(d3_pc), 1);
        check("lat3 stall_cnt", 32'(d3_sc), 3);
        end_cycle();

        // Memory wait in the middle of a LOAD_LAT=3 stall.
        do_reset();
        cur = lu_hit;
        begin_cycle();
        check("mw first bubble", 32'(d3_bub), 1);
        end_cycle();
        cur = idle();
        cur.dmem_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            check($sformatf("mw freeze %0d", k), 32'(d3_frz), 1);
            check($sformatf("mw no bubble %0d", k), 32'(d3_bub), 0);
            end_cycle();
        end
        cur.dmem_ready = 1'b1;
        begin_cycle();
        check("mw ready unfrozen", 32'(d3_frz), 0);
        check("mw bubble resume 0", 32'(d3_bub), 1);
        end_cycle();
        cur = idle();
        begin_cycle();
        check("mw bubble resume 1", 32'(d3_bub), 1);
        end_cycle();
        begin_cycle();
        check("mw released", 32'(d3_pc), 1);
        check("mw stall_cnt", 32'(d3_sc), 5);
        end_cycle();

        // Jump in RUN.
        do_reset();
        cur = idle();
        cur.jump = 1'b1;
        begin_cycle();
        check("jump flush", 32'(d1_fl), 1);
        end_cycle();
        cur = idle();
        begin_cycle();
        check("jump one cycle", 32'(d1_fl), 0);
        check("jump flush_cnt", 32'(d1_fc), 1);
        end_cycle();

        // Saturation of the 3-bit counter.
        do_reset();
        cur = idle();
        cur.dmem_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            begin_cycle();
            end_cycle();
        end
        cur = idle();
        begin_cycle();
        check("sat stall_cnt w3", 32'(d3_sc), 7);
        check("sat stall_cnt w16", 32'(d1_sc), 9);
        end_cycle();

        // Reset in the middle of a memory wait.
        do_reset();
        cur = lu_hit;
        cur.dmem_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            begin_cycle();
            end_cycle();
        end
        rst = 1'b1;
        begin_cycle();
        check("rst forces pc_write", 32'(d3_pc), 1);
        check("rst forces no freeze", 32'(d3_frz), 0);
        end_cycle();
        rst = 1'b0;
        cur = idle();
        cur.jump = 1'b1;
        begin_cycle();
        check("rst back to RUN", 32'(d3_fl), 1);
        check("rst stall_cnt", 32'(d3_sc), 0);
        check("rst flush_cnt", 32'(d1_fc), 0);
        end_cycle();

        // Random traffic with small register range to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            cur.id_rs         = 5'($urandom_range(0, 3));
            cur.id_rt         = 5'($urandom_range(0, 3));
            cur.id_uses_rs    = 1'($urandom_range(0, 1));
            cur.id_uses_rt    = 1'($urandom_range(0, 1));
            cur.ex_rs         = 5'($urandom_range(0, 3));
            cur.ex_rt         = 5'($urandom_range(0, 3));
            cur.ex_rd         = 5'($urandom_range(0, 3));
            cur.ex_mem_read   = 1'($urandom_range(0, 1));
            cur.mem_rd        = 5'($urandom_range(0, 3));
            cur.mem_reg_write = 1'($urandom_range(0, 1));
            cur.wb_rd         = 5'($urandom_range(0, 3));
            cur.wb_reg_write  = 1'($urandom_range(0, 1));
            cur.branch_taken  = ($urandom_range(0, 3) == 0);
            cur.jump          = ($urandom_range(0, 5) == 0);
            cur.dmem_req      = ($urandom_range(0, 2) == 0);
            cur.dmem_ready    = 1'($urandom_range(0, 1));
            rst               = ($urandom_range(0, 199) == 0);
            begin_cycle();
            end_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
# hazard_ctrl_pipe

Parametrised hazard and forwarding controller for the five-stage pipelined MIPS datapath. It sits alongside the main decoder in ID. It generates:
- EX-stage operand forwarding selects,
- multi-cycle load-use stalls with a configurable load latency,
- a global freeze while data memory is not ready,
- IF/ID flushes for taken branches and jumps.

Saturating performance counters record stall and flush cycles.

## Interface
Parameters:
- REG_AW, 5, register-address width; address 0 is never a hazard source.
- LOAD_LAT, 1, load-use bubble count, legal 1..3.
- CNT_W, 16, width of each performance counter.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  the ID instruction actually reads that source.
- ex_rs, ex_rt  in  REG_AW  source registers in ID/EX.
- ex_rd  in  REG_AW  destination in ID/EX.
- ex_mem_read  in  1  ID/EX holds a load.
- mem_rd  in  REG_AW  destination in EX/MEM.
- mem_reg_write  in  1  EX/MEM writes the register file.
- wb_rd  in  REG_AW  destination in MEM/WB.
- wb_reg_write  in  1  MEM/WB writes the register file.
- branch_taken, jump  in  1  ID-stage redirect request.
- dmem_req  in  1  MEM stage is accessing data memory this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write, ifid_write  out  1  PC and IF/ID enables.
- idex_bubble  out  1  load zeros (NOP) into ID/EX.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- ifid_flush  out  1  zero IF/ID.
- fwd_a, fwd_b  out  2  00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

## Operation
FSM states:
- RUN: normal operation.
- LU_STALL: down-counter `lu_left` active.
- MEM_WAIT: records whether to return to RUN or to LU_STALL.

Load-use detect (evaluated in RUN only):
- Condition: ex_mem_read, ex_rd != 0, and (id_uses_rs and id_rs == ex_rd) or (id_uses_rt and id_rt == ex_rd).
- Cycle of detect: idex_bubble=1, pc_write=0, ifid_write=0.
- If LOAD_LAT > 1: enter LU_STALL with lu_left = LOAD_LAT-1. LU_STALL repeats the same outputs and decrements lu_left each unfrozen cycle. It returns to RUN after the cycle in which lu_left reaches 1.

Memory wait:
- Condition: dmem_req and !dmem_ready, in any state.
- Effect: pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0.
- lu_left holds.
- The state becomes MEM_WAIT and remembers the prior state. It returns there in the cycle after dmem_ready arrives.
- The ready cycle itself is unfrozen.

Priority: memory wait > load-use > flush.
- branch_taken or jump asserts ifid_flush=1 only in RUN with no stall condition that cycle.
- A redirect during a stall is ignored. ID re-presents it once the stall ends.

Forwarding (combinational, independent of state):
- fwd_a = 10 if mem_reg_write, mem_rd != 0 and mem_rd == ex_rs.
- Otherwise fwd_a = 01 if wb_reg_write, wb_rd != 0 and wb_rd == ex_rs.
- Otherwise fwd_a = 00.
- fwd_b is the same rule using ex_rt.
- EX/MEM always wins over MEM/WB.

Counters:
- stall_cnt increments on every cycle with pc_write=0.
- flush_cnt increments on every cycle with ifid_flush=1.
- Both saturate at all-ones and never wrap.

Default outputs when none of the above applies: pc_write=1, ifid_write=1, all others 0.

## Timing
- Stall, freeze and flush outputs are combinational from the current state and inputs, with zero-cycle latency. State and counters update on the rising clk edge.
- Reset sampled high:
  - next state RUN, lu_left=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, outputs are forced: pc_write=1, ifid_write=1, idex_bubble=0, pipe_freeze=0, ifid_flush=0, fwd_a=fwd_b=00.
  - Reset during LU_STALL or MEM_WAIT abandons the stall immediately.
- A load-use stall costs exactly LOAD_LAT cycles with pc_write=0, excluding freeze cycles.
- A memory wait of N not-ready cycles adds exactly N cycles.
- With LOAD_LAT=3 the load has retired before release. The register file is write-before-read, so no forwarding is needed.
- A new load-use detect cannot occur until the state is RUN.

## Test plan
- Forwarding:
  - Stimulus: ex_rs=3, mem_rd=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1 → required: fwd_a=10.
  - Stimulus: clear mem_reg_write → required: fwd_a=01.
  - Stimulus: ex_rt=0, wb_rd=0, wb_reg_write=1 → required: fwd_b=00.
- Load-use, LOAD_LAT=1:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for one cycle.
  - Required: one cycle of idex_bubble=1, pc_write=0; stall_cnt 0→1.
  - Stimulus: same with id_uses_rs=0 → required: no stall.
- LOAD_LAT=3: one detect → required: exactly 3 consecutive bubble cycles, then pc_write=1; stall_cnt=3.
- Memory wait mid-stall (LOAD_LAT=3):
  - Stimulus: dmem_req=1, dmem_ready=0 for 2 cycles after the first bubble.
  - Required: pipe_freeze=1 for 2 cycles; bubbles resume for 2 more; stall_cnt=5.
- Redirect:
  - Stimulus: jump=1 in RUN → required: ifid_flush=1 for one cycle; flush_cnt=1.
  - Stimulus: jump=1 coincident with a load-use detect → required: ifid_flush=0.
- Saturation and reset:
  - Stimulus: CNT_W=3, 9 stall cycles → required: stall_cnt holds at 7.
  - Stimulus: assert rst mid-MEM_WAIT → required: next cycle is RUN with both counters 0.
